// File: rtl/kth_largest_alu_pkg.sv
// Shared definitions for the k-th largest ALU reduction engine: opcodes,
// FSM state encoding and the wide ALU function (callers truncate to DATA_W).
package kth_alu_pkg;

  localparam int ALU_W = 64;

  localparam logic [3:0] OP_ADD     = 4'd0;
  localparam logic [3:0] OP_SUB     = 4'd1;
  localparam logic [3:0] OP_AND     = 4'd2;
  localparam logic [3:0] OP_OR      = 4'd3;
  localparam logic [3:0] OP_XOR     = 4'd4;
  localparam logic [3:0] OP_MAX     = 4'd5;
  localparam logic [3:0] OP_MIN     = 4'd6;
  localparam logic [3:0] OP_ABSDIFF = 4'd7;
  localparam logic [3:0] OP_SHL     = 4'd8;
  localparam logic [3:0] OP_SHR     = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Operands arrive zero-extended; the low DATA_W bits of every result equal
  // the mod-2^DATA_W answer, so the caller simply keeps the low bits.
  function automatic logic [ALU_W-1:0] alu_f(input logic [3:0] op,
                                             input logic [ALU_W-1:0] a,
                                             input logic [ALU_W-1:0] b);
    logic [ALU_W-1:0] r;
    case (op)
      OP_ADD:     r = a + b;
      OP_SUB:     r = a - b;
      OP_AND:     r = a & b;
      OP_OR:      r = a | b;
      OP_XOR:     r = a ^ b;
      OP_MAX:     r = (a > b) ? a : b;
      OP_MIN:     r = (a < b) ? a : b;
      OP_ABSDIFF: r = (a > b) ? (a - b) : (b - a);
      OP_SHL:     r = a << b[2:0];
      OP_SHR:     r = a >> b[2:0];
      default:    r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/kth_largest_alu_if.sv
// Command, sample stream and report signals of the k-th largest ALU.
// Handshake: start is a one-cycle command; a sample is taken on any clk edge
// with valid=1 while busy=1 (never when start is also high); finish is a
// one-cycle pulse qualifying result/short, which then hold.
interface kth_largest_alu_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8,
  parameter int TOP_K  = 4
);
  localparam int RANK_W = $clog2(TOP_K + 1);

  logic              start;
  logic [CNT_W-1:0]  count;
  logic [RANK_W-1:0] rank_sel;
  logic              valid;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic [3:0]        instruction;
  logic [DATA_W-1:0] result;
  logic              finish;
  logic              short;
  logic              busy;
  kth_alu_pkg::state_t state;

  modport master (
    output start, count, rank_sel, valid, data_a, data_b, instruction,
    input  result, finish, short, busy, state
  );

  modport slave (
    input  start, count, rank_sel, valid, data_a, data_b, instruction,
    output result, finish, short, busy, state
  );
endinterface

// File: rtl/kth_largest_alu_topk_sorter.sv
// Descending bank of the TOP_K largest values seen since the last clear;
// one value is inserted per cycle by a parallel compare-and-shift.
module topk_sorter #(
  parameter int DATA_W = 8,
  parameter int TOP_K  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     ins_en,
  input  logic [DATA_W-1:0]        ins_data,
  output logic [DATA_W*TOP_K-1:0]  vals,
  output logic [TOP_K-1:0]         vlds
);
  logic [DATA_W-1:0] val_q   [TOP_K];
  logic [DATA_W-1:0] nxt_val [TOP_K];
  logic [TOP_K-1:0]  vld_q;
  logic [TOP_K-1:0]  nxt_vld;
  logic [TOP_K-1:0]  gt;

  // gt is monotone along the bank (descending, invalid slots at the tail), so
  // the first set bit is the insertion point and every later slot shifts down.
  // Strict '>' places a new value after existing equals.
  for (genvar g = 0; g < TOP_K; g++) begin : g_slot
    assign gt[g] = !vld_q[g] || (ins_data > val_q[g]);
    if (g == 0) begin : g_head
      assign nxt_val[g] = gt[g] ? ins_data : val_q[g];
      assign nxt_vld[g] = gt[g] | vld_q[g];
    end else begin : g_body
      assign nxt_val[g] = !gt[g] ? val_q[g] : (gt[g-1] ? val_q[g-1] : ins_data);
      assign nxt_vld[g] = !gt[g] ? vld_q[g] : (gt[g-1] ? vld_q[g-1] : 1'b1);
    end
    assign vals[g*DATA_W +: DATA_W] = val_q[g];
  end

  assign vlds = vld_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < TOP_K; i++) val_q[i] <= '0;
      vld_q <= '0;
    end else if (ins_en) begin
      val_q <= nxt_val;
      vld_q <= nxt_vld;
    end
  end
endmodule

// File: rtl/kth_largest_alu.sv
// Reduction engine: applies the ALU to each accepted operand pair, keeps the
// TOP_K largest results and reports the selected rank after count samples.
module kth_largest_alu
  import kth_alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8,
  parameter int TOP_K  = 4
) (
  input  logic clk,
  input  logic rst,
  kth_largest_alu_if.slave bus
);
  localparam int RANK_W = $clog2(TOP_K + 1);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        remaining;
  logic [RANK_W-1:0]       rank_q, rank_clamped;
  logic [DATA_W-1:0]       ins_data, result_q, pick_val;
  logic                    finish_q, short_q, pick_vld, ins_en;
  logic [DATA_W*TOP_K-1:0] bank_vals;
  logic [TOP_K-1:0]        bank_vlds;

  assign ins_en   = (state == ACCUM) && bus.valid && !bus.start;
  assign ins_data = DATA_W'(alu_f(bus.instruction, ALU_W'(bus.data_a), ALU_W'(bus.data_b)));

  topk_sorter #(.DATA_W(DATA_W), .TOP_K(TOP_K)) u_sorter (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.start),
    .ins_en   (ins_en),
    .ins_data (ins_data),
    .vals     (bank_vals),
    .vlds     (bank_vlds)
  );

  always_comb begin
    rank_clamped = bus.rank_sel;
    if (bus.rank_sel == '0)
      rank_clamped = RANK_W'(1);
    else if (bus.rank_sel > RANK_W'(TOP_K))
      rank_clamped = RANK_W'(TOP_K);
  end

  always_comb begin
    pick_val = '0;
    pick_vld = 1'b0;
    for (int i = 0; i < TOP_K; i++) begin
      if (rank_q == RANK_W'(i + 1)) begin
        pick_val = bank_vals[i*DATA_W +: DATA_W];
        pick_vld = bank_vlds[i];
      end
    end
  end

  // start in any state begins a fresh round; it outranks sample acceptance.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      ACCUM:   if (ins_en && remaining == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.start) state_nxt = (bus.count != '0) ? ACCUM : DONE;
  end

  // The report is captured on the edge leaving DONE, before a same-cycle
  // start clears the bank, so finish and result appear together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      rank_q    <= RANK_W'(1);
      result_q  <= '0;
      short_q   <= 1'b0;
      finish_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      finish_q <= (state == DONE);
      if (state == DONE) begin
        result_q <= pick_vld ? pick_val : '0;
        short_q  <= !pick_vld;
      end
      if (bus.start) begin
        remaining <= bus.count;
        rank_q    <= rank_clamped;
      end else if (ins_en) begin
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

  assign bus.result = result_q;
  assign bus.finish = finish_q;
  assign bus.short  = short_q;
  assign bus.busy   = (state == ACCUM);
  assign bus.state  = state;
endmodule

// File: tb/tb_kth_largest_alu.sv
// Bench for kth_largest_alu: an 8-bit/TOP_K=4 and a 16-bit/TOP_K=8 instance
// driven with directed rounds; expected reports are queued at round start.
module tb_kth_largest_alu;
  import kth_alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kth_largest_alu_if #(.DATA_W(8),  .CNT_W(8), .TOP_K(4)) a_if ();
  kth_largest_alu_if #(.DATA_W(16), .CNT_W(8), .TOP_K(8)) b_if ();

  kth_largest_alu #(.DATA_W(8),  .CNT_W(8), .TOP_K(4)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  kth_largest_alu #(.DATA_W(16), .CNT_W(8), .TOP_K(8)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  int tests_run    = 0;
  int tests_failed = 0;

  // Entries are {short, result}.
  logic [16:0] exp_a_q[$];
  logic [16:0] exp_b_q[$];

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input int d, input int res, input int sh);
    if (d == 0) exp_a_q.push_back({1'(sh), 16'(res)});
    else        exp_b_q.push_back({1'(sh), 16'(res)});
  endtask

  // junk=1 also raises valid with a large ADD pair that must be ignored.
  task automatic start_round(input int d, input int cnt, input int rank, input bit junk = 1'b0);
    if (d == 0) begin
      a_if.start = 1'b1; a_if.count = 8'(cnt); a_if.rank_sel = 3'(rank);
      a_if.valid = junk; a_if.instruction = 4'(OP_ADD); a_if.data_a = 8'd120; a_if.data_b = 8'd124;
    end else begin
      b_if.start = 1'b1; b_if.count = 8'(cnt); b_if.rank_sel = 4'(rank);
      b_if.valid = junk; b_if.instruction = 4'(OP_ADD); b_if.data_a = 16'd60000; b_if.data_b = 16'd10;
    end
    cycle();
    a_if.start = 1'b0; a_if.valid = 1'b0;
    b_if.start = 1'b0; b_if.valid = 1'b0;
  endtask

  task automatic send(input int d, input int op, input int x, input int y);
    if (d == 0) begin
      a_if.valid = 1'b1; a_if.instruction = 4'(op); a_if.data_a = 8'(x); a_if.data_b = 8'(y);
    end else begin
      b_if.valid = 1'b1; b_if.instruction = 4'(op); b_if.data_a = 16'(x); b_if.data_b = 16'(y);
    end
    cycle();
    a_if.valid = 1'b0;
    b_if.valid = 1'b0;
  endtask

  task automatic send_t1_pairs();
    send(0, OP_ADD, 1, 2);
    send(0, OP_ADD, 10, 5);
    send(0, OP_ADD, 7, 0);
    send(0, OP_ADD, 4, 4);
    send(0, OP_ADD, 200, 100);
  endtask

  // Monitor: every finish pulse must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    logic [16:0] e;
    if (a_if.finish) begin
      if (exp_a_q.size() == 0) begin
        tests_run++; tests_failed++;
        $display("FAIL a_unexpected_finish: got finish with result %0d, expected no finish", a_if.result);
      end else begin
        e = exp_a_q.pop_front();
        check("a_result", int'(a_if.result), int'(e[15:0]));
        check("a_short", int'(a_if.short), int'(e[16]));
      end
    end
    if (b_if.finish) begin
      if (exp_b_q.size() == 0) begin
        tests_run++; tests_failed++;
        $display("FAIL b_unexpected_finish: got finish with result %0d, expected no finish", b_if.result);
      end else begin
        e = exp_b_q.pop_front();
        check("b_result", int'(b_if.result), int'(e[15:0]));
        check("b_short", int'(b_if.short), int'(e[16]));
      end
    end
  end

  initial begin
    a_if.start = 1'b0; a_if.count = '0; a_if.rank_sel = '0; a_if.valid = 1'b0;
    a_if.data_a = '0; a_if.data_b = '0; a_if.instruction = '0;
    b_if.start = 1'b0; b_if.count = '0; b_if.rank_sel = '0; b_if.valid = 1'b0;
    b_if.data_a = '0; b_if.data_b = '0; b_if.instruction = '0;
    rst = 1'b1;
    cycle(); cycle();
    check("rst_a_result", int'(a_if.result), 0);
    check("rst_a_short",  int'(a_if.short), 0);
    check("rst_a_finish", int'(a_if.finish), 0);
    check("rst_a_busy",   int'(a_if.busy), 0);
    check("rst_b_result", int'(b_if.result), 0);
    check("rst_b_busy",   int'(b_if.busy), 0);
    rst = 1'b0;
    cycle();

    // ADD stream, rank 3 of {3,15,7,8,44}, with finish timing checks.
    expect_res(0, 8, 0);
    start_round(0, 5, 3);
    check("t1_busy", int'(a_if.busy), 1);
    send_t1_pairs();
    check("t1_finish_before", int'(a_if.finish), 0);
    cycle();
    check("t1_finish_rise", int'(a_if.finish), 1);
    cycle();
    check("t1_finish_fall", int'(a_if.finish), 0);
    check("t1_busy_after", int'(a_if.busy), 0);

    // Mixed ops with valid gaps: {251,48,200,240}, rank 1.
    expect_res(0, 251, 0);
    start_round(0, 4, 1);
    send(0, OP_SUB, 5, 10);    cycle();
    send(0, OP_AND, 8'hF0, 8'h3C); cycle();
    send(0, OP_MAX, 9, 200);   cycle();
    send(0, OP_XOR, 8'hFF, 8'h0F);
    repeat (3) cycle();

    // Duplicates count toward rank.
    expect_res(0, 10, 0);
    start_round(0, 4, 2);
    repeat (4) send(0, OP_ADD, 5, 5);
    repeat (3) cycle();

    // count=0 reports immediately with short set.
    expect_res(0, 0, 1);
    start_round(0, 0, 1);
    check("t4_zero_finish_before", int'(a_if.finish), 0);
    cycle();
    check("t4_zero_finish_rise", int'(a_if.finish), 1);
    cycle();

    // Fewer samples than the rank.
    expect_res(0, 0, 1);
    start_round(0, 2, 3);
    send(0, OP_ADD, 1, 1);
    send(0, OP_ADD, 2, 2);
    repeat (3) cycle();

    // rank_sel clamping: 0 -> 1, 7 -> TOP_K.
    expect_res(0, 44, 0);
    start_round(0, 5, 0);
    send_t1_pairs();
    repeat (2) cycle();
    expect_res(0, 7, 0);
    start_round(0, 5, 7);
    send_t1_pairs();
    repeat (2) cycle();

    // Remaining ops, plus a valid sample alongside start that must be ignored.
    // {7,2,16,53,50,77} -> rank 4 = 16.
    expect_res(0, 16, 0);
    start_round(0, 6, 4, 1'b1);
    send(0, OP_ABSDIFF, 3, 10);
    send(0, OP_SHL, 8'h81, 9);
    send(0, OP_SHR, 8'h80, 3);
    send(0, OP_OR, 8'h05, 8'h30);
    send(0, OP_MIN, 100, 50);
    send(0, 12, 77, 1);
    repeat (3) cycle();

    // start during DONE: both rounds report.
    expect_res(0, 8, 0);
    start_round(0, 1, 1);
    send(0, OP_ADD, 4, 4);
    expect_res(0, 5, 0);
    start_round(0, 1, 1);
    send(0, OP_ADD, 2, 3);
    repeat (3) cycle();

    // Reset mid-round abandons it without a report.
    start_round(0, 5, 1);
    send(0, OP_ADD, 1, 1);
    send(0, OP_ADD, 2, 2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t5_busy",   int'(a_if.busy), 0);
    check("t5_finish", int'(a_if.finish), 0);
    check("t5_result", int'(a_if.result), 0);
    check("t5_short",  int'(a_if.short), 0);
    repeat (3) cycle();
    expect_res(0, 18, 0);
    start_round(0, 3, 1);
    send(0, OP_ADD, 1, 1);
    send(0, OP_ADD, 9, 9);
    send(0, OP_ADD, 3, 3);
    repeat (3) cycle();

    // Wide instance: rank 8 of {7,1007,...,9007}.
    expect_res(1, 2007, 0);
    start_round(1, 10, 8);
    check("t6_b_busy", int'(b_if.busy), 1);
    for (int i = 0; i < 10; i++) send(1, OP_ADD, i * 1000, 7);
    repeat (3) cycle();

    // Restart mid-round: only the second round reports.
    start_round(1, 10, 8);
    send(1, OP_ADD, 9000, 9000);
    send(1, OP_ADD, 100, 100);
    cycle();
    expect_res(1, 2, 0);
    start_round(1, 1, 1);
    send(1, OP_ADD, 1, 1);
    repeat (4) cycle();

    for (int i = 0; i < 50 && (exp_a_q.size() + exp_b_q.size()) > 0; i++) cycle();
    if ((exp_a_q.size() + exp_b_q.size()) > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL missing_finish: got %0d outstanding reports, expected 0",
               exp_a_q.size() + exp_b_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
